// File: rtl/vram_arbiter.sv
// Display/CPU arbiter for a single-port synchronous video RAM; the display always wins.
// Build option: define VRAM_ARB_BLANK_ONLY_EN to restrict CPU grants to vertical blanking.
module vram_arbiter #(
    parameter int AW           = 15,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 200
) (
    input  logic          dot_clock,
    input  logic          reset,
    input  logic          vblank,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_starve,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // state  | meaning
    // S_IDLE | no access on mem_*
    // S_DISP | display read on mem_*
    // S_CPU  | CPU access on mem_*, cpu_ack high
    typedef enum logic [1:0] {S_IDLE, S_DISP, S_CPU} state_t;

    localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

    state_t     state;
    state_t     state_next;
    logic       cpu_elig;
    logic [7:0] wait_cnt;
    logic [7:0] wait_next;

`ifdef VRAM_ARB_BLANK_ONLY_EN
    assign cpu_elig = vblank;
`else
    // vblank has no effect on eligibility in this build
    assign cpu_elig = vblank | 1'b1;
`endif

    assign disp_rdata = mem_rdata;
    assign cpu_rdata  = mem_rdata;

    // A request seen while cpu_ack is high is the one already granted, so it is skipped.
    always_comb begin
        state_next = S_IDLE;
        if (disp_req)
            state_next = S_DISP;
        else if (cpu_elig && cpu_req && state != S_CPU)
            state_next = S_CPU;
    end

    always_comb begin
        wait_next = wait_cnt;
        if (!cpu_req || state_next == S_CPU)
            wait_next = 8'd0;
        else if (state != S_CPU && wait_cnt != 8'hFF)
            wait_next = wait_cnt + 8'd1;
    end

    always_ff @(posedge dot_clock) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 8'd0;
            cpu_starve  <= 1'b0;
            cpu_ack     <= 1'b0;
            disp_rvalid <= 1'b0;
            cpu_rvalid  <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (wait_next >= STARVE_LIM8)
                cpu_starve <= 1'b1;
            cpu_ack     <= (state_next == S_CPU);
            mem_en      <= (state_next != S_IDLE);
            disp_rvalid <= (state == S_DISP);
            cpu_rvalid  <= (state == S_CPU) && !mem_we;
            case (state_next)
                S_DISP: begin
                    mem_addr <= disp_addr;
                    mem_we   <= 1'b0;
                end
                S_CPU: begin
                    mem_addr  <= cpu_addr;
                    mem_we    <= cpu_we;
                    mem_wdata <= cpu_wdata;
                end
                default: mem_we <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small synchronous RAM model attached.
module tb_vram_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;

    logic          dot_clock = 1'b0;
    logic          reset;
    logic          vblank;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_starve;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_err    = 0;
    int ack_cnt  = 0;
    int wr_cnt   = 0;
    int crv_cnt  = 0;
    int both_cnt = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(10)) dut (
        .dot_clock(dot_clock), .reset(reset), .vblank(vblank),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_starve(cpu_starve),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 dot_clock = ~dot_clock;

    always @(posedge dot_clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    always @(negedge dot_clock) begin
        if (cpu_ack) ack_cnt++;
        if (mem_en && mem_we) wr_cnt++;
        if (cpu_rvalid) crv_cnt++;
        if (cpu_rvalid && disp_rvalid) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge dot_clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        ram[15'h0123] = 8'h5A;
        ram[15'h0010] = 8'h77;
        mem_rdata = '0;
        reset = 1'b1; vblank = 1'b0;
        disp_req = 1'b0; disp_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        step(); step();
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_rvalids", {30'd0, disp_rvalid, cpu_rvalid}, 32'd0);
        check("rst_starve", 32'(cpu_starve), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        step();

        // display read
        disp_req = 1'b1; disp_addr = 15'h0123;
        step();
        check("disp_mem_en", 32'(mem_en), 32'd1);
        check("disp_mem_addr", 32'(mem_addr), 32'h0123);
        check("disp_mem_we", 32'(mem_we), 32'd0);
        disp_req = 1'b0;
        step();
        check("disp_rvalid", 32'(disp_rvalid), 32'd1);
        check("disp_rdata", 32'(disp_rdata), 32'h5A);
        step();
        check("disp_rvalid_drop", 32'(disp_rvalid), 32'd0);

        // CPU write with handshake
        ack_cnt = 0; wr_cnt = 0; crv_cnt = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0040; cpu_wdata = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            step();
            if (cpu_ack) cpu_req = 1'b0;
        end
        step(); step();
        check("wr_ack_pulses", 32'(ack_cnt), 32'd1);
        check("wr_mem_writes", 32'(wr_cnt), 32'd1);
        check("wr_ram_data", 32'(ram[15'h0040]), 32'hC3);
        check("wr_no_rvalid", 32'(crv_cnt), 32'd0);

        // display beats CPU for four cycles, then CPU read is granted
        cpu_we = 1'b0; cpu_addr = 15'h0010; cpu_req = 1'b1; disp_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            disp_addr = 15'(16'h0200 + i);
            step();
            check("tie_disp_addr", 32'(mem_addr), 32'(16'h0200 + i));
            check("tie_no_ack", 32'(cpu_ack), 32'd0);
        end
        check("tie_wait_cnt", 32'(dut.wait_cnt), 32'd4);
        disp_req = 1'b0;
        step();
        check("tie_cpu_ack", 32'(cpu_ack), 32'd1);
        check("tie_cpu_addr", 32'(mem_addr), 32'h0010);
        check("tie_wait_clear", 32'(dut.wait_cnt), 32'd0);
        cpu_req = 1'b0;
        step();
        check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("rd_cpu_rdata", 32'(cpu_rdata), 32'h77);
        check("rd_disp_rvalid", 32'(disp_rvalid), 32'd0);
        step();

        // back-to-back requests: at most one grant every two cycles
        cpu_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("peak_ack", 32'(cpu_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        cpu_req = 1'b0;
        step(); step();

        // starvation at limit 10
        disp_req = 1'b1; cpu_req = 1'b1;
        for (int i = 0; i < 9; i++) step();
        check("starve_before", 32'(cpu_starve), 32'd0);
        step();
        check("starve_at_10", 32'(cpu_starve), 32'd1);
        disp_req = 1'b0; cpu_req = 1'b0;
        step(); step(); step();
        check("starve_sticky", 32'(cpu_starve), 32'd1);

        // reset clears starvation
        reset = 1'b1;
        step();
        check("rst_starve_clr", 32'(cpu_starve), 32'd0);
        reset = 1'b0;
        step();

        // reset right after a CPU read grant flushes the return
        crv_cnt = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
        step();
        check("flush_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        reset = 1'b1;
        step();
        check("flush_outs", {26'd0, mem_en, mem_we, cpu_ack, disp_rvalid, cpu_rvalid, cpu_starve}, 32'd0);
        check("flush_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        step(); step();
        check("flush_no_rvalid", 32'(crv_cnt), 32'd0);

        // requests present during reset are dropped
        reset = 1'b1; disp_req = 1'b1; cpu_req = 1'b1;
        step();
        check("rstreq_mem_en", 32'(mem_en), 32'd0);
        check("rstreq_ack", 32'(cpu_ack), 32'd0);
        reset = 1'b0; disp_req = 1'b0; cpu_req = 1'b0;
        step();
        check("rstreq_idle", {30'd0, mem_en, disp_rvalid}, 32'd0);
        step();

`ifdef VRAM_ARB_BLANK_ONLY_EN
        vblank = 1'b0; cpu_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("blank_hold", 32'(cpu_ack), 32'd0);
        end
        vblank = 1'b1;
        step();
        check("blank_grant", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
`else
        vblank = 1'b0; cpu_req = 1'b1;
        step();
        check("active_grant", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
`endif
        step(); step();
        check("never_both_rvalid", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter AW, default 15, memory address width.
REQ-002 Parameter DW, default 8, memory data width.
REQ-003 Parameter STARVE_LIMIT, default 200, CPU wait cycles before the starvation flag sets; legal range 1-255.
REQ-004 dot_clock  in  1  sole clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 vblank  in  1  vertical blanking from the timing generator.
REQ-007 disp_req  in  1  display fetch request; no handshake, always honoured.
REQ-008 disp_addr  in  AW  display fetch address.
REQ-009 disp_rvalid  out  1  display read data valid.
REQ-010 disp_rdata  out  DW  display read data, driven directly from mem_rdata.
REQ-011 cpu_req, cpu_we  in  1 each  CPU request and write-enable.
REQ-012 cpu_addr  in  AW; cpu_wdata  in  DW  CPU request payload.
REQ-013 cpu_ack  out  1  one-cycle pulse when the CPU access is issued to memory.
REQ-014 cpu_rvalid  out  1; cpu_rdata  out  DW  CPU read return; cpu_rdata driven directly from mem_rdata.
REQ-015 cpu_starve  out  1  sticky starvation flag.
REQ-016 mem_en, mem_we  out  1 each; mem_addr  out  AW; mem_wdata  out  DW  registered single-port synchronous RAM port.
REQ-017 mem_rdata  in  DW  RAM read data, valid one cycle after mem_en is high with mem_we low.

Function
REQ-018 State machine states: IDLE (no access), DISP (display access on mem_*), CPU (CPU access on mem_*, cpu_ack high). The next state is computed from inputs sampled in cycle t; mem_* are registered and valid in cycle t+1.
REQ-019 Priority: disp_req high gives next state DISP, with mem_addr=disp_addr, mem_we=0; the display always wins ties.
REQ-020 Otherwise, if the CPU is eligible, cpu_req is high and the current state is not CPU, the next state is CPU, with mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
REQ-021 cpu_req is ignored in any cycle in which cpu_ack is high; the same request is never granted twice; peak CPU throughput is one access per 2 cycles.
REQ-022 In all other cases the next state is IDLE, with mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their previous values.
REQ-023 The CPU holds cpu_req, cpu_we, cpu_addr and cpu_wdata stable until it samples cpu_ack high; changing the payload earlier is illegal and is not checked.
REQ-024 Read latency: a display request in cycle t gives disp_rvalid=1 in cycle t+2.
REQ-025 Read latency: a CPU read granted (cpu_ack) in cycle t+1 gives cpu_rvalid=1 in cycle t+2.
REQ-026 CPU writes never assert cpu_rvalid.
REQ-027 disp_rvalid and cpu_rvalid are never high in the same cycle.
REQ-028 Wait counter (8 bit): increments each cycle cpu_req=1 and the next state is not CPU, excluding cpu_ack cycles.
REQ-029 The wait counter clears when a CPU grant occurs or when cpu_req=0, and saturates at 255.
REQ-030 cpu_starve sets when the wait counter reaches STARVE_LIMIT and stays set until reset.
REQ-031 A memory access is never issued with mem_we=1 for the display.

Reset
REQ-032 Reset clears: state=IDLE; mem_en, mem_we, cpu_ack, disp_rvalid, cpu_rvalid and cpu_starve to 0; mem_addr and mem_wdata to 0; wait counter to 0.
REQ-033 Reset asserted mid-access flushes the rvalid pipeline; any in-flight read returns no valid.
REQ-034 An interrupted, un-acked CPU request is not granted during reset; the CPU re-presents it after reset.
REQ-035 Requests sampled in the reset cycle are discarded.

Configuration
REQ-036 Macro VRAM_ARB_BLANK_ONLY_EN defined: CPU eligible only while vblank=1, giving tear-free updates; the display still has priority.
REQ-037 Macro VRAM_ARB_BLANK_ONLY_EN undefined: CPU eligible every cycle and is granted in any cycle where disp_req=0.

Verification
REQ-038 Stimulus: disp_req=1, disp_addr=0x0123, mem returns 0x5A. Required: mem_en=1, mem_addr=0x0123 at t+1; disp_rvalid=1, disp_rdata=0x5A at t+2.
REQ-039 Stimulus: cpu_req held with cpu_we=1, cpu_addr=0x0040, cpu_wdata=0xC3 for 3 cycles, disp_req=0. Required: exactly one cpu_ack pulse; exactly one write of 0xC3 to 0x0040.
REQ-040 Stimulus: disp_req and cpu_req both high for 4 cycles, then disp_req=0. Required: 4 DISP accesses first, then the CPU is granted; the wait counter reads 4 before the grant.
REQ-041 Stimulus: STARVE_LIMIT=10, disp_req stuck high, cpu_req high. Required: cpu_starve rises in the cycle the count reaches 10 and stays high after cpu_req drops.
REQ-042 Stimulus: reset pulsed in the cycle after a CPU read is issued. Required: no cpu_rvalid; all outputs 0 in the cycle after reset.
REQ-043 Stimulus: VRAM_ARB_BLANK_ONLY_EN defined, cpu_req=1, vblank=0, disp_req=0. Required: no grant; grant issued the first cycle after vblank=1 is sampled.
